// File: rtl/truth_table_checker_if.sv
// Stimulus/response and status bundle between the truth-table checker and its environment.
// The checker drives A/B/C and status; the environment drives start and the D/E responses.
interface truth_table_checker_if;
  logic       start;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       E;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       first_fail_valid;
  logic [2:0] first_fail_idx;

  modport master (
    input  start, D, E,
    output A, B, C, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );

  modport slave (
    output start, D, E,
    input  A, B, C, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive checker for a 3-input/2-output combinational block: sweeps {A,B,C} 0..7,
// samples D/E at the end of each hold window and counts mismatches against EXP_D/EXP_E.
module truth_table_checker #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [7:0]  EXP_D       = 8'hEA,
  parameter logic [7:0]  EXP_E       = 8'h96
) (
  input logic                    clk,
  input logic                    rst_n,
  truth_table_checker_if.master  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0] CntLast = 8'(HOLD_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       ffv_q, ffv_d;
  logic [2:0] ffi_q, ffi_d;
  logic       mismatch;

  assign mismatch = (bus.D != EXP_D[idx_q]) || (bus.E != EXP_E[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          err_d   = 4'd0;
          ffv_d   = 1'b0;
          ffi_d   = 3'd0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CntLast) begin
          if (mismatch) begin
            err_d = err_q + 4'd1;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q;
            end
          end
          cnt_d = 8'd0;
          // idx stays at 7 in DONE so the stimulus holds 111
          if (idx_q == 3'd7) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 4'd0;
      ffv_q   <= 1'b0;
      ffi_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  assign bus.A                = idx_q[2];
  assign bus.B                = idx_q[1];
  assign bus.C                = idx_q[0];
  assign bus.busy             = (state_q == StRun);
  assign bus.done             = (state_q == StDone);
  assign bus.pass             = (state_q == StDone) && (err_q == 4'd0);
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: a cycle-count model of the sweep checked every cycle, plus
// hand-computed end-of-sweep expectations for each directed scenario.
module tb_truth_table_checker;

  localparam int H = 4;

  logic clk;
  logic rst_n;
  truth_table_checker_if bus ();

  int checks   = 0;
  int failures = 0;

  // Fault controls for the emulated unit under test
  logic       e_tie0  = 1'b0;
  logic       d_inv6  = 1'b0;
  logic       glitch3 = 1'b0;
  logic [2:0] abc;
  logic [2:0] abc_last = 3'd0;

  truth_table_checker #(
    .HOLD_CYCLES (H),
    .EXP_D       (8'hEA),
    .EXP_E       (8'h96)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  function automatic logic dref(input logic [2:0] v);
    return v[0] | (v[2] & v[1]);
  endfunction

  function automatic logic eref(input logic [2:0] v);
    return v[2] ^ v[1] ^ v[0];
  endfunction

  assign abc   = {bus.A, bus.B, bus.C};
  assign bus.D = dref(abc) ^ (d_inv6 && abc == 3'd6) ^ (glitch3 && abc == 3'd3 && abc_last != 3'd3);
  assign bus.E = e_tie0 ? 1'b0 : eref(abc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mk counts cycles into the sweep (1..8H); vector = (mk-1)/H, sampled when (mk-1)%H == H-1
  bit          mrun  = 1'b0;
  bit          mdone = 1'b0;
  int          mk    = 0;
  int unsigned merr  = 0;
  bit          mffv  = 1'b0;
  int unsigned mffi  = 0;

  always @(negedge clk) begin
    int unsigned exp_abc;
    logic [2:0]  vec;
    exp_abc = mrun ? int'((mk - 1) / H) : (mdone ? 7 : 0);
    chk("busy", bus.busy, mrun);
    chk("done", bus.done, mdone);
    chk("pass", bus.pass, mdone && merr == 0);
    chk("abc", abc, exp_abc);
    chk("err_count", bus.err_count, merr);
    chk("first_fail_valid", bus.first_fail_valid, mffv);
    chk("first_fail_idx", bus.first_fail_idx, mffi);
    abc_last <= abc;

    if (!rst_n) begin
      mrun = 0; mdone = 0; mk = 0; merr = 0; mffv = 0; mffi = 0;
    end else if (mrun) begin
      if ((mk - 1) % H == H - 1) begin
        vec = 3'((mk - 1) / H);
        if (bus.D != dref(vec) || bus.E != eref(vec)) begin
          merr++;
          if (!mffv) begin
            mffv = 1;
            mffi = vec;
          end
        end
      end
      if (mk == 8 * H) begin
        mrun  = 0;
        mdone = 1;
      end else begin
        mk++;
      end
    end else if (bus.start) begin
      mrun = 1; mdone = 0; mk = 1; merr = 0; mffv = 0; mffi = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pulse, then watch 40 cycles; optionally re-pulse start mid-run
  task automatic run_sweep(input bit mid, output int busy_cycles);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        chk("cleared_err", bus.err_count, 0);
        chk("cleared_ffv", bus.first_fail_valid, 0);
        chk("cleared_done", bus.done, 0);
      end
      if (bus.busy) busy_cycles++;
      bus.start = mid && (i == 10);
      tick(1);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int bc;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    tick(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_abc", abc, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_count, 0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick(2);

    // Correct unit
    run_sweep(1'b0, bc);
    chk("s2_busy_len", bc, 32);
    chk("s2_done", bus.done, 1);
    chk("s2_pass", bus.pass, 1);
    chk("s2_err", bus.err_count, 0);
    chk("s2_ffv", bus.first_fail_valid, 0);
    chk("s2_abc_done", abc, 7);

    // E stuck at 0: vectors 1,2,4,7 fail
    e_tie0 = 1'b1;
    run_sweep(1'b0, bc);
    e_tie0 = 1'b0;
    chk("s3_err", bus.err_count, 4);
    chk("s3_ffi", bus.first_fail_idx, 1);
    chk("s3_ffv", bus.first_fail_valid, 1);
    chk("s3_pass", bus.pass, 0);

    // D wrong at vector 6, plus a non-sampled glitch on vector 3
    d_inv6  = 1'b1;
    glitch3 = 1'b1;
    run_sweep(1'b0, bc);
    d_inv6  = 1'b0;
    glitch3 = 1'b0;
    chk("s4_err", bus.err_count, 1);
    chk("s4_ffi", bus.first_fail_idx, 6);
    chk("s4_pass", bus.pass, 0);

    // Restart from failing DONE with a mid-run start pulse
    run_sweep(1'b1, bc);
    chk("s5_busy_len", bc, 32);
    chk("s5_pass", bus.pass, 1);
    chk("s5_err", bus.err_count, 0);

    // Reset while idx=3
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(13);
    chk("s6_abc_before", abc, 3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("s6_busy", bus.busy, 0);
    chk("s6_abc", abc, 0);
    chk("s6_err", bus.err_count, 0);
    chk("s6_done", bus.done, 0);
    tick(2);
    run_sweep(1'b0, bc);
    chk("s6_busy_len", bc, 32);
    chk("s6_pass", bus.pass, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Synthesizable exhaustive checker for 3-input/2-output combinational logic blocks. It drives every input combination {A,B,C} = 000…111 in ascending order, holds each for a fixed number of cycles, and samples the block's outputs D and E at the end of each hold window. Each sample is compared against an expected truth table. Errors are counted and the first failing vector is latched. It sits beside a combinational unit on the board or in a top-level wrapper, in place of a simulation-only stimulus fixture.

## Interface

Parameters:
- HOLD_CYCLES, 10: cycles each vector is held; legal range 2..255.
- EXP_D, 8'hEA: expected D; bit i = value for vector index i, where i = {A,B,C} with A as MSB. Default is D = C | (A&B).
- EXP_E, 8'h96: expected E, same indexing. Default is E = A^B^C.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle request to begin a sweep.
- A, output, 1: stimulus MSB, registered.
- B, output, 1: stimulus middle bit, registered.
- C, output, 1: stimulus LSB, registered.
- D, input, 1: DUT output under test.
- E, input, 1: DUT output under test.
- busy, output, 1: sweep in progress.
- done, output, 1: sweep complete; held until next accepted start or reset.
- pass, output, 1: done && err_count == 0.
- err_count, output, 4: number of failing vectors in last sweep, 0..8.
- first_fail_valid, output, 1: at least one failure latched.
- first_fail_idx, output, 3: index of first failing vector.

## Operation

- One clock; reset is synchronous and active-low. rst_n low at a rising edge forces:
  - state IDLE;
  - A=B=C=0, busy=0, done=0, pass=0;
  - err_count=0, first_fail_valid=0, first_fail_idx=0.
- Internal state: 3-bit vector index idx, 8-bit hold counter cnt, and FSM {IDLE, RUN, DONE}.
- {A,B,C} always equals idx while in RUN, and 000 in IDLE. In DONE, {A,B,C} holds 111.
- IDLE:
  - start=1 → RUN, with idx=0, cnt=0, err_count=0, first_fail_valid=0, first_fail_idx=0.
- RUN:
  - cnt increments each cycle.
  - When cnt == HOLD_CYCLES-1, sample D and E and compare them to EXP_D[idx] and EXP_E[idx].
  - A mismatch on D, on E, or on both counts as one error for that vector: err_count += 1.
  - If first_fail_valid=0 at a mismatch, latch first_fail_idx=idx and set first_fail_valid=1.
  - After the sample: if idx==7 → DONE; otherwise idx += 1 and cnt = 0.
  - start is ignored in RUN.
- DONE:
  - done=1, busy=0. err_count and first-fail fields hold.
  - start=1 → RUN, with all results cleared exactly as from IDLE. done drops in the same cycle busy rises.
- err_count saturates naturally at 8; it never wraps, since a sweep has at most 8 vectors.
- Simultaneous rst_n low and start: reset wins.

## Timing

- start is sampled at edge t. At t+1: busy=1 and {A,B,C}=000.
- Vector i is driven from cycle t+1+i·HOLD_CYCLES for HOLD_CYCLES cycles. D/E are sampled on the last cycle of that window, which gives the DUT HOLD_CYCLES-1 cycles to settle.
- err_count and first_fail_* update at the edge ending the sample cycle, so they are visible one cycle later.
- busy is high for exactly 8·HOLD_CYCLES cycles. done=1 and pass become valid at t+1+8·HOLD_CYCLES.
- Reset mid-RUN: the next cycle shows IDLE values, and the partial results are discarded.

## Test plan

1. Hold rst_n=0 for 2 cycles with start=1 → all outputs 0, busy stays 0.
2. HOLD_CYCLES=4, correct DUT model (D=C|(A&B), E=A^B^C), start pulse → busy high 32 cycles, {A,B,C} steps 000..111 every 4 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
3. E tied to 0 → err_count=4 (vectors 1, 2, 4, 7), first_fail_idx=1, first_fail_valid=1, pass=0.
4. D inverted only at vector 6 → err_count=1, first_fail_idx=6; then inject a D glitch on the first (non-sample) cycle of vector 3 → no extra error counted.
5. Pulse start again mid-RUN → ignored, sweep length unchanged. Pulse start in DONE after a failing run, with a correct DUT → results cleared at the next edge, and the new sweep ends with pass=1.
6. Drive rst_n=0 for one cycle while idx=3 → next cycle IDLE, {A,B,C}=000, busy=0, err_count=0. A subsequent start performs a full 8-vector sweep.
